pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 34 +++
 rtl/pipe_skid_reg_slot.sv | 36 +++
 rtl/pipe_skid_reg.sv | 104 ++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared constants for the pipeline stage register: payload field widths,
// the NOP encoding and the bubble payload, plus the main-slot action type.
package pipe_skid_reg_pkg;

   // Payload field widths, packed as {waddr, we, wdata, aluop, mem_addr}.
   // Carrying reg2 appends REG2_W more bits (107 in total).
   localparam int WADDR_W    = 5;
   localparam int WE_W       = 1;
   localparam int WDATA_W    = 32;
   localparam int ALUOP_W    = 5;
   localparam int MEM_ADDR_W = 32;
   localparam int REG2_W     = 32;
   localparam int PAYLOAD_W  = WADDR_W + WE_W + WDATA_W + ALUOP_W + MEM_ADDR_W;

   // ALU opcode of a no-operation; a bubble is a NOP that writes nothing.
   localparam logic [ALUOP_W-1:0] NOP_OP = '0;

   localparam logic [PAYLOAD_W-1:0] BUBBLE_DEFAULT =
      {{WADDR_W{1'b0}}, {WE_W{1'b0}}, {WDATA_W{1'b0}}, NOP_OP, {MEM_ADDR_W{1'b0}}};

   // What the main slot does at the coming edge.
   typedef enum logic [1:0] {
      MAIN_HOLD,
      MAIN_LOAD_IN,
      MAIN_LOAD_SKID,
      MAIN_CLEAR
   } main_act_e;

   // Number of valid entries held; both inputs are register outputs.
   function automatic logic [1:0] occ_count(input logic main_vld, input logic skid_vld);
      return {1'b0, main_vld} + {1'b0, skid_vld};
   endfunction

endpackage

// File: rtl/pipe_skid_reg_slot.sv
// One storage slot: a payload register plus valid bit. Clear wins over load,
// which is what lets flush override any transfer into the slot.
module pipe_skid_reg_slot #(
   parameter int                DATA_W = 75,
   parameter logic [DATA_W-1:0] BUBBLE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q,
   output logic              vld
);

   logic [DATA_W-1:0] data_q;
   logic              vld_q;

   // Slot state: reset/clear to an invalid bubble, otherwise capture on load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= BUBBLE;
         vld_q  <= 1'b0;
      end else if (clr) begin
         data_q <= BUBBLE;
         vld_q  <= 1'b0;
      end else if (load) begin
         data_q <= d;
         vld_q  <= 1'b1;
      end
   end

   assign q   = data_q;
   assign vld = vld_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a ready/valid handshake on both sides.
// With SKID_EN=1 a second (skid) slot absorbs the beat accepted while the
// downstream stalls, so in_ready comes straight from a flop and never sees
// out_ready combinationally. With SKID_EN=0 it is a single slot whose ready
// is the usual !full|out_ready. A legacy stall input maps to out_ready=!stall.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int                DATA_W  = PAYLOAD_W,
   parameter int                SKID_EN = 1,
   parameter logic [DATA_W-1:0] BUBBLE  = DATA_W'(BUBBLE_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   localparam logic SKID_ON = (SKID_EN != 0);

   logic              main_vld_q;
   logic              skid_vld_q;
   logic [DATA_W-1:0] main_data_q;
   logic [DATA_W-1:0] skid_data_q;

   logic              accept;
   logic              consume;
   main_act_e         main_act_d;
   logic              skid_load_d;
   logic              main_load;
   logic              main_clr;
   logic              skid_clr;
   logic [DATA_W-1:0] main_data_d;

   assign consume  = main_vld_q & out_ready;
   // The skid slot only fills when main is full, so !skid is the free-space flag.
   assign in_ready = SKID_ON ? !skid_vld_q : (!main_vld_q | out_ready);
   assign accept   = in_valid & in_ready;

   // Decide the slot transfers for the coming edge; flush overrides everything.
   always_comb begin
      main_act_d  = MAIN_HOLD;
      skid_load_d = 1'b0;
      if (flush) begin
         main_act_d = MAIN_CLEAR;
      end else if (!main_vld_q || consume) begin
         // Main is free at the edge: the older skid entry goes first. When the
         // skid is full in_ready is low, so no accept can collide with it.
         if (skid_vld_q) begin
            main_act_d = MAIN_LOAD_SKID;
         end else if (accept) begin
            main_act_d = MAIN_LOAD_IN;
         end else if (main_vld_q) begin
            main_act_d = MAIN_CLEAR;
         end
      end else if (accept) begin
         // Main is stalled; only reachable with the skid slot enabled.
         skid_load_d = 1'b1;
      end
   end

   assign main_load   = (main_act_d == MAIN_LOAD_IN) || (main_act_d == MAIN_LOAD_SKID);
   assign main_clr    = (main_act_d == MAIN_CLEAR);
   assign main_data_d = (main_act_d == MAIN_LOAD_SKID) ? skid_data_q : in_data;
   assign skid_clr    = flush || (main_act_d == MAIN_LOAD_SKID);

   pipe_skid_reg_slot #(
      .DATA_W (DATA_W),
      .BUBBLE (BUBBLE)
   ) u_main (
      .clk  (clk),
      .rst  (rst),
      .clr  (main_clr),
      .load (main_load),
      .d    (main_data_d),
      .q    (main_data_q),
      .vld  (main_vld_q)
   );

   // Never loaded when SKID_EN=0, so it reduces to constant bubble/invalid.
   pipe_skid_reg_slot #(
      .DATA_W (DATA_W),
      .BUBBLE (BUBBLE)
   ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .clr  (skid_clr),
      .load (skid_load_d & SKID_ON),
      .d    (in_data),
      .q    (skid_data_q),
      .vld  (skid_vld_q)
   );

   assign out_valid = main_vld_q;
   assign out_data  = main_data_q;
   assign occupancy = occ_count(main_vld_q, skid_vld_q);

endmodule
